// File: rtl/mult_unit.sv
// Iterative shift-add signed multiplier that sits beside the EX-stage ALU.
// Stalls the pipeline while a MULT runs, then commits the product into HI/LO.
module mult_unit #(
    parameter int          DATA_W  = 32,
    parameter logic [3:0]  MULT_OP = 4'd14,
    parameter int          CNT_W   = 6
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              ex_valid,
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_e              state_q, state_d;
    logic [DATA_W:0]     acc_q, acc_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                start;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     shift_acc;
    logic [DATA_W-1:0]   shift_mplier;
    logic [2*DATA_W-1:0] prod_mag, prod;

    // Flush outranks start; ex_valid low behaves like any non-MULT code.
    assign start = ex_valid && (alu_control == MULT_OP) && !flush;

    always_comb begin
        // Unsigned negation maps -2^(DATA_W-1) onto itself, which is its magnitude.
        abs_a = operand_a[DATA_W-1] ? -operand_a : operand_a;
        abs_b = operand_b[DATA_W-1] ? -operand_b : operand_b;

        sum          = mplier_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
        shift_acc    = {1'b0, sum[DATA_W:1]};
        shift_mplier = {sum[0], mplier_q[DATA_W-1:1]};
        prod_mag     = {shift_acc[DATA_W-1:0], shift_mplier};
        prod         = neg_q ? -prod_mag : prod_mag;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = abs_a;
                    mplier_d = abs_b;
                    neg_d    = operand_a[DATA_W-1] ^ operand_b[DATA_W-1];
                    acc_d    = '0;
                    cnt_d    = CNT_INIT;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    // Aborted MULT: partial product dropped, HI/LO untouched.
                    state_d = S_IDLE;
                end else begin
                    acc_d    = shift_acc;
                    mplier_d = shift_mplier;
                    cnt_d    = cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        hi_d    = prod[2*DATA_W-1:DATA_W];
                        lo_d    = prod[DATA_W-1:0];
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // The MULT still in EX here is the one just finished; never restart it.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // The stall is combinational so the issuing cycle already holds IF/ID/EX.
    assign stall = arst_n && (((state_q == S_IDLE) && start) ||
                              ((state_q == S_RUN) && !flush));
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: stimulus pushes expected HI/LO, a monitor
// pops and compares on every done pulse.
module tb_mult_unit;

    localparam logic [3:0] MULT_OP = 4'd14;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        ex_valid = 1'b0;
    logic [3:0]  alu_control = 4'd0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb[$];
    logic [63:0] model_hilo = '0;

    mult_unit #(.DATA_W(32), .MULT_OP(MULT_OP), .CNT_W(6)) dut (
        .clk(clk), .arst_n(arst_n), .ex_valid(ex_valid), .alu_control(alu_control),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full signed product from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        return sa * sb_;
    endfunction

    always @(negedge clk) begin
        logic [63:0] e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected: got done=1 expected done=0");
            end else begin
                e = sb.pop_front();
                chk("hilo_on_done", {hi, lo}, e);
            end
        end
    end

    task automatic idle();
        ex_valid    = 1'b0;
        alu_control = 4'd0;
        flush       = 1'b0;
    endtask

    // Called at a negedge. kill: 0 none, 1 flush at cycle kill_at, 2 reset at cycle kill_at.
    // Returns at the negedge following the last EX cycle of this instruction.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int kill, input int kill_at);
        int k;
        int nstall;
        logic [63:0] e;
        nstall      = 0;
        ex_valid    = 1'b1;
        alu_control = MULT_OP;
        operand_a   = a;
        operand_b   = b;
        flush       = 1'b0;
        e = ref_mult(a, b);
        if (kill == 0) sb.push_back(e);
        for (k = 0; k < 100; k++) begin
            if (k > 0) begin
                operand_a = $urandom;
                operand_b = $urandom;
            end
            if (kill == 1 && k == kill_at) flush = 1'b1;
            if (kill == 2 && k == kill_at) arst_n = 1'b0;
            #1;
            if (kill == 2 && k == kill_at) begin
                chk("reset_stall", 64'(stall), 64'd0);
                chk("reset_busy", 64'(busy), 64'd0);
                chk("reset_done", 64'(done), 64'd0);
                chk("reset_hilo", {hi, lo}, 64'd0);
                model_hilo = '0;
                sb.delete();
                break;
            end
            if (k == 1) chk("busy_in_run", 64'(busy), 64'd1);
            if (!stall) break;
            nstall++;
            @(negedge clk);
        end
        if (k >= 100) begin
            checks++;
            failures++;
            $display("FAIL stall_timeout: got stall still high after %0d cycles expected release", k);
        end
        chk("stall_cycles", 64'(nstall), (kill == 0) ? 64'd33 : 64'(kill_at));
        if (kill == 0) model_hilo = e;
        @(negedge clk);
        flush = 1'b0;
        if (kill == 1) begin
            chk("busy_after_flush", 64'(busy), 64'd0);
            chk("hilo_after_flush", {hi, lo}, model_hilo);
        end
    endtask

    task automatic pass_through(input logic [3:0] code, input logic valid);
        ex_valid    = valid;
        alu_control = code;
        operand_a   = $urandom;
        operand_b   = $urandom;
        flush       = 1'b0;
        #1;
        chk("pass_stall", 64'(stall), 64'd0);
        @(negedge clk);
        chk("pass_busy", 64'(busy), 64'd0);
        chk("pass_hilo", {hi, lo}, model_hilo);
    endtask

    initial begin
        logic [3:0] code;
        logic       v;
        #1 arst_n = 1'b0;
        ex_valid = 1'b1;
        alu_control = MULT_OP;
        operand_a = 32'd7;
        operand_b = 32'd6;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        issue(32'd7, 32'd6, 0, 0);
        chk("basic_hilo", {hi, lo}, 64'h0000_0000_0000_002A);

        issue(32'hFFFF_FFFD, 32'd5, 0, 0);
        issue(32'h8000_0000, 32'h8000_0000, 0, 0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        idle();
        @(negedge clk);
        chk("signed_last_hilo", {hi, lo}, 64'h0000_0000_0000_0001);

        issue(32'd7, 32'd6, 0, 0);
        idle();
        @(negedge clk);
        pass_through(4'd2, 1'b1);
        pass_through(4'd5, 1'b1);
        pass_through(4'd0, 1'b1);
        pass_through(4'd7, 1'b1);
        pass_through(MULT_OP, 1'b0);

        issue(32'd100, 32'd100, 1, 10);
        idle();
        @(negedge clk);
        issue(32'd2, 32'd3, 0, 0);
        chk("after_flush_lo", 64'(lo), 64'd6);

        issue(32'd4, 32'd5, 0, 0);
        chk("b2b_lo", 64'(lo), 64'd20);
        idle();
        @(negedge clk);

        issue(32'd9, 32'd9, 2, 17);
        idle();
        @(negedge clk);
        #1 chk("rst_mid_stall", 64'(stall), 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        issue(32'd3, 32'hFFFF_FFFE, 0, 0);
        idle();
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            code = 4'($urandom_range(0, 15));
            v    = 1'($urandom_range(0, 3) != 0);
            if (i % 3 == 0) code = MULT_OP;
            if (code == MULT_OP && v) begin
                if ($urandom_range(0, 4) == 0)
                    issue($urandom, $urandom, 1, $urandom_range(0, 32));
                else
                    issue($urandom, $urandom, 0, 0);
                idle();
                @(negedge clk);
            end else begin
                pass_through(code, v);
            end
        end

        idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
